aes_inv_key_sched: RTL and testbench
====================================

Name: aes_inv_key_sched

Overview:
- Upstream key supplier for the AES-128 decryption datapath.
- Accepts a 128-bit cipher key and expands it to all 11 round keys, one round per cycle, into an internal buffer.
- Then streams the keys in reverse order (10 down to 0) over a valid/ready handshake to the round logic.
- Flags the initial AddRoundKey key (round 10) and the final-round key (round 0), which skips InvMixColumns.

Parameters:
- NR, 10, number of AES rounds. Fixed for AES-128; any other value is unsupported.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- key_in  in  128  cipher key; bits [127:120] = byte 0
- key_load  in  1  start strobe; sampled only in IDLE
- busy  out  1  high from EXPAND through SERVE
- round_key  out  128  current round key
- rk_round  out  4  index of round_key (10..0)
- rk_initial  out  1  high with round 10 (initial AddRoundKey)
- is_final_round  out  1  high with round 0
- rk_valid  out  1  round_key valid
- rk_ready  in  1  consumer accepts
- done  out  1  one-cycle pulse after round 0 transfers
- replay  in  1  re-serve stored keys (optional feature only)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy, rk_valid, rk_initial, is_final_round, done all 0.
  - round_key=0, rk_round=0; key buffer cleared to 0.
  - Reset asserted mid-EXPAND or mid-SERVE aborts immediately; no partial output follows.
- FSM states: IDLE -> EXPAND -> SERVE -> IDLE.
- IDLE:
  - key_load=1 at edge T: buffer[0]<=key_in, step counter<=1, state<=EXPAND.
  - busy=1 from T+1.
- EXPAND:
  - One round per cycle: buffer[i]<=expand_step(buffer[i-1], rcon[i]), for i=1..10.
  - rcon = 01,02,04,08,10,20,40,80,1B,36.
  - On i=10, state<=SERVE.
  - rk_valid rises at T+11 with rk_round=10, round_key=buffer[10], rk_initial=1.
- SERVE:
  - Transfer occurs when rk_valid && rk_ready.
  - round_key, rk_round and the flags hold stable while rk_valid && !rk_ready.
  - On transfer of round r>0, the next cycle presents r-1, so back-to-back transfers are possible every cycle.
  - rk_initial=1 only for r=10; is_final_round=1 only for r=0.
- Round 0 transfer:
  - Next cycle: rk_valid=0, busy=0, done=1 for one cycle, state=IDLE.
  - key_load is accepted again that same cycle (done cycle).
- key_load while busy: ignored; no restart, no error.
- replay without the feature: ignored.
- rk_ready is a don't-care while rk_valid=0.
- Expansion, per 32-bit word w0..w3 of the previous key:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
- Width rules: all XOR on 32-bit words; rk_round is a 4-bit down-counter with no wrap (stops at 0).

Optional Feature:
- Macro AES_INV_KEY_SCHED_REPLAY_EN.
- Defined:
  - Buffer and a keys_stored flag are retained after done.
  - replay=1 in IDLE with keys_stored=1 goes directly to SERVE; first rk_valid one cycle after the replay edge, without re-expansion.
  - key_load has priority over replay in the same cycle.
  - keys_stored is cleared by reset and set at the end of EXPAND.
- Undefined:
  - replay port is present but ignored; no keys_stored register exists.

Decomposition:
- Shared package aes_pkg:
  - AES_NR=10
  - rcon table (10 x 8-bit)
  - state enum {IDLE, EXPAND, SERVE}
  - 128-bit key and 32-bit word typedefs
- Sub-module aes_key_expand_step: combinational; prev_key[127:0] + rcon[7:0] -> next_key[127:0].
  - Uses four instances of the existing forward S-box for SubWord.
- Top level holds the FSM, counters, 11x128 buffer and handshake.

Test Plan:
- Key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> first key at T+11 is round 10 d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_initial=1. Round 1 must be a0fafe1788542cb123a339392a6c7605; round 0 returns the key with is_final_round=1; done 1 cycle after.
- Key 000102030405060708090a0b0c0d0e0f -> round 10 13111d7fe3944a17f307a78b4d2b30c5; 11 transfers in 11 consecutive cycles.
- Random rk_ready throttling (~50% duty) -> round_key and rk_round stable across stalls; exact sequence 10..0, no duplicates or skips.
- key_load pulsed during EXPAND and during SERVE -> ignored; output sequence identical to the unperturbed run.
- rst_n dropped at round 5 of SERVE -> all outputs 0 asynchronously. A fresh key_load after release produces the full correct sequence.
- With AES_INV_KEY_SCHED_REPLAY_EN defined: after done, assert replay -> rk_valid one cycle later with round 10, same 11 keys. Without the macro, replay does nothing.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 types, round constants and forward S-box lookup.
// Imported by the inverse key scheduler and its expansion step.
package aes_pkg;

   localparam int AES_NR = 10;

   typedef logic [127:0] key_t;
   typedef logic [31:0]  word_t;

   typedef enum logic [1:0] {
      IDLE,
      EXPAND,
      SERVE
   } state_t;

   localparam logic [7:0] RCON [AES_NR] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Byte 0 of the table sits in the top byte, so entry b lives at
   // bit offset (255-b)*8, which is simply {~b, 3'b000}.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TBL[{~b, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/aes_key_expand_step.sv
// One AES-128 key expansion round, purely combinational.
// Ports: prev_key (round i-1 key), rcon (round constant) -> next_key.
module aes_key_expand_step
   import aes_pkg::*;
(
   input  logic [127:0] prev_key,
   input  logic [7:0]   rcon,
   output logic [127:0] next_key
);

   word_t w0, w1, w2, w3;
   word_t rot, sub, t;
   word_t n0, n1, n2, n3;

   assign {w0, w1, w2, w3} = prev_key;

   assign rot = {w3[23:0], w3[31:24]};

   assign sub = {sbox(rot[31:24]), sbox(rot[23:16]),
                 sbox(rot[15:8]),  sbox(rot[7:0])};

   assign t  = sub ^ {rcon, 24'h0};
   assign n0 = w0 ^ t;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;

   assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 key supplier for decryption: expands a cipher key into 11
// round keys (one per cycle), then streams them round 10 down to 0
// over a valid/ready handshake.
// Ports: clk, rst_n (async low); key_in/key_load start a run;
// round_key/rk_round/rk_initial/is_final_round/rk_valid/rk_ready
// form the output stream; busy spans EXPAND..SERVE; done pulses
// once after round 0 is taken. replay re-serves the stored keys
// only when AES_INV_KEY_SCHED_REPLAY_EN is defined.
module aes_inv_key_sched
   import aes_pkg::*;
#(
   parameter int NR = AES_NR
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [127:0] key_in,
   input  logic         key_load,
   output logic         busy,
   output logic [127:0] round_key,
   output logic [3:0]   rk_round,
   output logic         rk_initial,
   output logic         is_final_round,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic         done,
   input  logic         replay
);

   state_t      state_q, state_d;
   logic [3:0]  step_q, step_d;
   logic [3:0]  rnd_q, rnd_d;
   logic        done_q, done_d;
   key_t        buf_q [0:NR];
   key_t        buf_d [0:NR];
   logic [3:0]  prev_idx;
   key_t        next_key;

`ifdef AES_INV_KEY_SCHED_REPLAY_EN
   logic        ks_q, ks_d;
`else
   logic        unused_replay;
   assign unused_replay = replay;
`endif

   assign prev_idx = (step_q == 4'd0) ? 4'd0 : step_q - 4'd1;

   aes_key_expand_step u_step (
      .prev_key (buf_q[prev_idx]),
      .rcon     (RCON[prev_idx]),
      .next_key (next_key)
   );

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      rnd_d   = rnd_q;
      done_d  = 1'b0;
      buf_d   = buf_q;
`ifdef AES_INV_KEY_SCHED_REPLAY_EN
      ks_d    = ks_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (key_load) begin
               buf_d[0] = key_in;
               step_d   = 4'd1;
               state_d  = EXPAND;
`ifdef AES_INV_KEY_SCHED_REPLAY_EN
            end else if (replay && ks_q) begin
               rnd_d   = 4'(NR);
               state_d = SERVE;
`endif
            end
         end
         EXPAND: begin
            buf_d[step_q] = next_key;
            step_d        = step_q + 4'd1;
            if (step_q == 4'(NR)) begin
               step_d  = 4'd0;
               rnd_d   = 4'(NR);
               state_d = SERVE;
`ifdef AES_INV_KEY_SCHED_REPLAY_EN
               ks_d    = 1'b1;
`endif
            end
         end
         SERVE: begin
            if (rk_ready) begin
               if (rnd_q == 4'd0) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  rnd_d = rnd_q - 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         step_q  <= 4'd0;
         rnd_q   <= 4'd0;
         done_q  <= 1'b0;
         for (int i = 0; i <= NR; i++) buf_q[i] <= '0;
`ifdef AES_INV_KEY_SCHED_REPLAY_EN
         ks_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         rnd_q   <= rnd_d;
         done_q  <= done_d;
         buf_q   <= buf_d;
`ifdef AES_INV_KEY_SCHED_REPLAY_EN
         ks_q    <= ks_d;
`endif
      end
   end

   // Outputs are gated by SERVE so nothing stale shows outside it.
   assign busy           = (state_q != IDLE);
   assign rk_valid       = (state_q == SERVE);
   assign round_key      = rk_valid ? buf_q[rnd_q] : '0;
   assign rk_round       = rnd_q;
   assign rk_initial     = rk_valid && (rnd_q == 4'(NR));
   assign is_final_round = rk_valid && (rnd_q == 4'd0);
   assign done           = done_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed self-checking bench for aes_inv_key_sched.
// Expected keys come from the FIPS-197 key expansion examples.
module tb_aes_inv_key_sched;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [127:0] key_in = '0;
   logic         key_load = 1'b0;
   logic         busy;
   logic [127:0] round_key;
   logic [3:0]   rk_round;
   logic         rk_initial;
   logic         is_final_round;
   logic         rk_valid;
   logic         rk_ready = 1'b0;
   logic         done;
   logic         replay = 1'b0;

   aes_inv_key_sched dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .key_in         (key_in),
      .key_load       (key_load),
      .busy           (busy),
      .round_key      (round_key),
      .rk_round       (rk_round),
      .rk_initial     (rk_initial),
      .is_final_round (is_final_round),
      .rk_valid       (rk_valid),
      .rk_ready       (rk_ready),
      .done           (done),
      .replay         (replay)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   logic [127:0] kf [0:10] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
   };
   localparam logic [127:0] K0     = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K0_R1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
   localparam logic [127:0] K0_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   logic [127:0] obs_key  [0:10];
   logic [3:0]   obs_rnd  [0:10];
   logic         obs_init [0:10];
   logic         obs_fin  [0:10];
   int ntx, cyc, stall_bad;

   task automatic load_key(input logic [127:0] k, input bit perturb,
                           output int lat, output logic busy1,
                           output logic valid1);
      key_in   = k;
      key_load = 1'b1;
      @(negedge clk);
      key_load = 1'b0;
      lat    = 1;
      busy1  = busy;
      valid1 = rk_valid;
      while (!rk_valid && lat < 40) begin
         if (perturb && lat == 4) begin
            key_in   = ~k;
            key_load = 1'b1;
         end else begin
            key_load = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      key_load = 1'b0;
   endtask

   task automatic drain(input int duty, input int kl_at, input int max_tx);
      logic [127:0] pk;
      logic [3:0]   pr;
      bit           hold;
      bit           rdy;
      ntx = 0; cyc = 0; stall_bad = 0; hold = 0; pk = '0; pr = '0;
      for (int i = 0; i < 11; i++) begin
         obs_key[i] = '0; obs_rnd[i] = '0;
         obs_init[i] = 1'b0; obs_fin[i] = 1'b0;
      end
      while (ntx < max_tx && cyc < 200) begin
         key_in   = K0;
         key_load = (cyc == kl_at);
         if (rk_valid) begin
            if (hold && (round_key !== pk || rk_round !== pr))
               stall_bad++;
            rdy = (int'($urandom_range(99)) < duty);
            rk_ready = rdy;
            if (rdy) begin
               obs_key[ntx]  = round_key;
               obs_rnd[ntx]  = rk_round;
               obs_init[ntx] = rk_initial;
               obs_fin[ntx]  = is_final_round;
               ntx++;
               hold = 0;
            end else begin
               hold = 1; pk = round_key; pr = rk_round;
            end
         end else begin
            rk_ready = 1'($urandom_range(1));
         end
         @(negedge clk);
         cyc++;
      end
      key_load = 1'b0;
      rk_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      vectors++;
      if ({busy, rk_valid, rk_initial, is_final_round, done,
           rk_round, round_key} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got busy=%b vld=%b rnd=%0d key=%h want all 0",
                  busy, rk_valid, rk_round, round_key);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if ({busy, rk_valid, done} !== 3'b000) begin
         miscompares++;
         $display("FAIL post_reset_idle: got busy=%b vld=%b done=%b want 000",
                  busy, rk_valid, done);
      end
   endtask

   task automatic test_fips();
      int lat; logic b1, v1;
      load_key(kf[0], 1'b0, lat, b1, v1);
      vectors++;
      if (b1 !== 1'b1 || v1 !== 1'b0) begin
         miscompares++;
         $display("FAIL fips_busy_t1: got busy=%b vld=%b want busy=1 vld=0", b1, v1);
      end
      vectors++;
      if (lat !== 11) begin
         miscompares++;
         $display("FAIL fips_latency: got %0d want 11", lat);
      end
      vectors++;
      if (round_key !== kf[10] || rk_round !== 4'd10 || rk_initial !== 1'b1) begin
         miscompares++;
         $display("FAIL fips_first: got rnd=%0d key=%h ini=%b want rnd=10 key=%h ini=1",
                  rk_round, round_key, rk_initial, kf[10]);
      end
      drain(100, -1, 11);
      vectors++;
      if (ntx !== 11 || cyc !== 11) begin
         miscompares++;
         $display("FAIL fips_count: got ntx=%0d cyc=%0d want 11/11", ntx, cyc);
      end
      for (int i = 0; i < 11; i++) begin
         vectors++;
         if (obs_rnd[i] !== 4'(10 - i) || obs_key[i] !== kf[10 - i] ||
             obs_init[i] !== (i == 0) || obs_fin[i] !== (i == 10)) begin
            miscompares++;
            $display("FAIL fips_seq[%0d]: got rnd=%0d key=%h ini=%b fin=%b want rnd=%0d key=%h",
                     i, obs_rnd[i], obs_key[i], obs_init[i], obs_fin[i], 10 - i, kf[10 - i]);
         end
      end
      vectors++;
      if (done !== 1'b1 || busy !== 1'b0 || rk_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL fips_done: got done=%b busy=%b vld=%b want 1/0/0",
                  done, busy, rk_valid);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0) begin
         miscompares++;
         $display("FAIL fips_done_pulse: got done=%b want 0", done);
      end
   endtask

   task automatic test_back_to_back();
      int lat; logic b1, v1;
      load_key(K0, 1'b0, lat, b1, v1);
      vectors++;
      if (lat !== 11 || round_key !== K0_R10) begin
         miscompares++;
         $display("FAIL b2b_first: got lat=%0d key=%h want lat=11 key=%h",
                  lat, round_key, K0_R10);
      end
      drain(100, -1, 11);
      vectors++;
      if (ntx !== 11 || cyc !== 11) begin
         miscompares++;
         $display("FAIL b2b_count: got ntx=%0d cyc=%0d want 11/11", ntx, cyc);
      end
      vectors++;
      if (obs_key[0] !== K0_R10 || obs_key[9] !== K0_R1 || obs_key[10] !== K0 ||
          obs_fin[10] !== 1'b1 || obs_rnd[9] !== 4'd1) begin
         miscompares++;
         $display("FAIL b2b_keys: got r10=%h r1=%h r0=%h want %h %h %h",
                  obs_key[0], obs_key[9], obs_key[10], K0_R10, K0_R1, K0);
      end
      vectors++;
      if (done !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_done: got %b want 1", done);
      end
      load_key(kf[0], 1'b0, lat, b1, v1);
      vectors++;
      if (b1 !== 1'b1 || lat !== 11 || round_key !== kf[10]) begin
         miscompares++;
         $display("FAIL reload_in_done: got busy=%b lat=%0d key=%h want 1 11 %h",
                  b1, lat, round_key, kf[10]);
      end
      drain(100, -1, 11);
   endtask

   task automatic test_throttle();
      int lat; logic b1, v1;
      load_key(kf[0], 1'b0, lat, b1, v1);
      drain(50, -1, 11);
      vectors++;
      if (ntx !== 11 || stall_bad !== 0 || cyc <= 11) begin
         miscompares++;
         $display("FAIL thr_stall: got ntx=%0d bad=%0d cyc=%0d want 11 0 >11",
                  ntx, stall_bad, cyc);
      end
      for (int i = 0; i < 11; i++) begin
         vectors++;
         if (obs_rnd[i] !== 4'(10 - i) || obs_key[i] !== kf[10 - i]) begin
            miscompares++;
            $display("FAIL thr_seq[%0d]: got rnd=%0d key=%h want rnd=%0d key=%h",
                     i, obs_rnd[i], obs_key[i], 10 - i, kf[10 - i]);
         end
      end
   endtask

   task automatic test_load_ignored();
      int lat; logic b1, v1;
      load_key(kf[0], 1'b1, lat, b1, v1);
      vectors++;
      if (lat !== 11 || round_key !== kf[10]) begin
         miscompares++;
         $display("FAIL ign_expand: got lat=%0d key=%h want 11 %h", lat, round_key, kf[10]);
      end
      drain(100, 3, 11);
      for (int i = 0; i < 11; i++) begin
         vectors++;
         if (obs_rnd[i] !== 4'(10 - i) || obs_key[i] !== kf[10 - i]) begin
            miscompares++;
            $display("FAIL ign_seq[%0d]: got rnd=%0d key=%h want rnd=%0d key=%h",
                     i, obs_rnd[i], obs_key[i], 10 - i, kf[10 - i]);
         end
      end
      vectors++;
      if (done !== 1'b1) begin
         miscompares++;
         $display("FAIL ign_done: got %b want 1", done);
      end
   endtask

   task automatic test_replay();
      int bad;
      @(negedge clk);
      replay = 1'b1;
      @(negedge clk);
      replay = 1'b0;
`ifdef AES_INV_KEY_SCHED_REPLAY_EN
      vectors++;
      if (rk_valid !== 1'b1 || rk_round !== 4'd10 || round_key !== kf[10]) begin
         miscompares++;
         $display("FAIL replay_first: got vld=%b rnd=%0d key=%h want 1 10 %h",
                  rk_valid, rk_round, round_key, kf[10]);
      end
      drain(100, -1, 11);
      for (int i = 0; i < 11; i++) begin
         vectors++;
         if (obs_rnd[i] !== 4'(10 - i) || obs_key[i] !== kf[10 - i]) begin
            miscompares++;
            $display("FAIL replay_seq[%0d]: got rnd=%0d key=%h want rnd=%0d key=%h",
                     i, obs_rnd[i], obs_key[i], 10 - i, kf[10 - i]);
         end
      end
`else
      bad = 0;
      repeat (12) begin
         if (rk_valid || busy) bad++;
         @(negedge clk);
      end
      vectors++;
      if (bad !== 0) begin
         miscompares++;
         $display("FAIL replay_ignored: got %0d active cycles want 0", bad);
      end
`endif
   endtask

   task automatic test_reset_abort();
      int lat, bad; logic b1, v1;
      load_key(kf[0], 1'b0, lat, b1, v1);
      drain(100, -1, 5);
      vectors++;
      if (rk_round !== 4'd5 || round_key !== kf[5]) begin
         miscompares++;
         $display("FAIL abort_pre: got rnd=%0d key=%h want 5 %h", rk_round, round_key, kf[5]);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({busy, rk_valid, rk_initial, is_final_round, done,
           rk_round, round_key} !== '0) begin
         miscompares++;
         $display("FAIL abort_async: got busy=%b vld=%b rnd=%0d key=%h want all 0",
                  busy, rk_valid, rk_round, round_key);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (rk_valid || busy || done) bad++;
      end
      vectors++;
      if (bad !== 0) begin
         miscompares++;
         $display("FAIL abort_quiet: got %0d active cycles want 0", bad);
      end
      load_key(K0, 1'b0, lat, b1, v1);
      drain(100, -1, 11);
      vectors++;
      if (lat !== 11 || ntx !== 11 || obs_key[0] !== K0_R10 ||
          obs_key[9] !== K0_R1 || obs_key[10] !== K0 || obs_rnd[10] !== 4'd0) begin
         miscompares++;
         $display("FAIL abort_rerun: got lat=%0d ntx=%0d r10=%h r0=%h want 11 11 %h %h",
                  lat, ntx, obs_key[0], obs_key[10], K0_R10, K0);
      end
   endtask

   initial begin
      test_reset();
      test_fips();
      test_back_to_back();
      test_throttle();
      test_load_ignored();
      test_replay();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
